seg_scan_mux: RTL
=================

# seg_scan_mux

Four-digit multiplexed seven-segment scan driver for the countdown game board. Sits directly downstream of the countdown counter: it takes the live count (0–99) and a display mode, and generates the time-multiplexed `seg`/`an`/`dp` pins. It replaces the ad-hoc counter-compare scanning in the top level. Binary-to-BCD conversion is sequential, and inputs are frame-synchronous so a digit never tears mid-frame.

## Interface
- `SLOT_CYCLES`, 12500 — clocks per digit slot (50 MHz / 4 kHz); must be ≥ 16.
- `GAP_CYCLES`, 64 — anti-ghost blank clocks at the start of each slot; must be ≥ 1 and < `SLOT_CYCLES`.
- `clk`  in  1 — system clock, 50 MHz.
- `reset`  in  1 — asynchronous, active-low reset.
- `mode`  in  2 — 0 BANNER, 1 NUMBER, 2 WIN, 3 LOSE.
- `value`  in  7 — count to show in NUMBER mode; values > 99 clamp to 99.
- `blank_lz`  in  1 — 1 blanks the tens digit when it is 0.
- `seg`  out  7 — active-low segments; `seg[6]`=g … `seg[0]`=a.
- `an`  out  4 — active-low anodes; `an[3]` is the leftmost digit.
- `dp`  out  1 — active-low decimal point.
- `frame_tick`  out  1 — one-cycle pulse at the start of each frame (slot 0, cycle 0).

## Operation
- Slot FSM cycles SLOT3 → SLOT0 → SLOT1 → SLOT2 → SLOT3. Slot k drives `an[3-k]`; the frame starts at SLOT0.
- Slot counter runs 0..`SLOT_CYCLES`-1, then wraps and advances the slot.
- For cycles 0..`GAP_CYCLES`-1 of every slot: `an`=1111, `seg`=1111111.
- Shadow capture on the first cycle of SLOT3: `mode`, `blank_lz`, and `value` (clamped) are latched into shadow registers.
- BCD converter FSM:
  - States: IDLE → CONV → DONE.
  - CONV subtracts 10 per cycle, incrementing tens, until the remainder is < 10.
  - Worst case is 10 cycles; the result is committed to `tens_r`/`ones_r` on DONE, before SLOT0.
- The display uses only committed shadow/BCD registers. Input changes mid-frame are invisible until the next SLOT3 capture.
- Glyphs:
  - 0–9 standard, e.g. 0=1000000, 1=1111001.
  - C=1000110, L=1000111, U=1000001, blank=1111111.
- Per-mode content for digits 3/2/1/0:
  - BANNER: C / L / 0 / blank.
  - NUMBER: tens / ones / blank / blank. Tens is blank when `tens_r`=0 and the shadow `blank_lz`=1.
  - WIN: blank / blank / U / U.
  - LOSE: blank / blank / L / blank.
- A blank digit keeps its anode high for the whole slot.
- `dp` is 1 (off) except as set by the configuration feature.
- Reset, asynchronous, including mid-frame or mid-conversion:
  - `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0.
  - Slot FSM = SLOT3, counter = 0, converter IDLE.
  - Shadow mode = BANNER, shadow value = 0, `tens_r`=`ones_r`=0.
- First capture happens on the first clock after reset deasserts.

## Timing
- All outputs are registered; no combinational path from input to output.
- Input-to-display latency: from the SLOT3 capture edge to SLOT0 output is `SLOT_CYCLES`+`GAP_CYCLES` clocks.
- Worst case from an arbitrary input change is 5×`SLOT_CYCLES`+`GAP_CYCLES`.
- Frame period is 4×`SLOT_CYCLES` clocks; `frame_tick` is high for exactly one clock each frame.
- Within a slot, `an` and `seg` change on the same edge (gap end / slot end); an anode is never low while `seg` transitions.
- Value 99 converts in 10 CONV cycles; value 0 converts in 1 CONV cycle.

## Configuration
- `SEG_SCAN_DP_HEARTBEAT_EN` defined:
  - An 8-bit frame counter (reset 0) increments on every `frame_tick`.
  - In NUMBER mode, `dp` on digit 2 (`an[2]` slot, non-gap cycles) is 0 while counter bit 7 = 1.
  - This gives a visible "running" blink.
- Not defined: `dp` is constant 1; no frame counter exists.

## Test plan
- Reset low for 5 clocks mid-SLOT1 → `an`=1111, `seg`=1111111, `dp`=1 immediately. After release, the first SLOT0 shows `an`=0111, `seg`=1000110 (C).
- `mode`=1, `value`=47, `SLOT_CYCLES`=16, `GAP_CYCLES`=2 → per frame: `an`=0111/`seg`=1111000 (7 is wrong digit: tens is 4) — specifically tens slot `seg`=0011001 (4), ones slot `an`=1011/`seg`=1111000 (7). `an`=1111 during each 2-cycle gap. `frame_tick` every 64 clocks.
- `value`=5 with `blank_lz`=1 → tens slot `an` stays 1111, ones slot shows 0010010. With `blank_lz`=0 → tens slot shows 1000000.
- `value`=120 → displays 9/9. Measure CONV duration = 10 cycles, completed before SLOT0.
- `mode`=2 then 3 toggled mid-SLOT1 → the current frame is unchanged. The next frame shows `an[1]`,`an[0]` = U,U for WIN, or `an[1]` = L (1000111) for LOSE.
- With `SEG_SCAN_DP_HEARTBEAT_EN`, NUMBER mode, 256 frames → `dp`=0 during the `an[2]` slot for frames 128–255 only.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Pin bundle for the four-digit scan driver.
// master: the countdown logic side (drives mode/value/blank_lz, sees the pins).
// slave : seg_scan_mux itself (reads the controls, drives seg/an/dp/frame_tick).
interface seg_scan_mux_if;
    logic [1:0] mode;
    logic [6:0] value;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_tick;

    modport master (output mode, value, blank_lz, input seg, an, dp, frame_tick);
    modport slave  (input mode, value, blank_lz, output seg, an, dp, frame_tick);
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment scan driver.
// Slots run SLOT3 -> SLOT0 -> SLOT1 -> SLOT2; slot k lights an[3-k].
// Inputs are sampled once per frame at the start of SLOT3. The 0-99 value goes through
// a subtract-by-ten BCD converter, and everything the digits show is reloaded
// only at the SLOT3 -> SLOT0 boundary, so no digit changes mid-frame.
// Optional feature macro: SEG_SCAN_DP_HEARTBEAT_EN (frame-counter dp blink on digit 2).
module seg_scan_mux #(
    parameter int SLOT_CYCLES = 12500,
    parameter int GAP_CYCLES  = 64
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_mux_if.slave bus
);
    localparam int            CW       = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CONV = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [1:0] M_BANNER = 2'd0;
    localparam logic [1:0] M_NUMBER = 2'd1;
    localparam logic [1:0] M_WIN    = 2'd2;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_C     = 7'b1000110;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_U     = 7'b1000001;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'b1000000;
            4'd1:    digit_glyph = 7'b1111001;
            4'd2:    digit_glyph = 7'b0100100;
            4'd3:    digit_glyph = 7'b0110000;
            4'd4:    digit_glyph = 7'b0011001;
            4'd5:    digit_glyph = 7'b0010010;
            4'd6:    digit_glyph = 7'b0000010;
            4'd7:    digit_glyph = 7'b1111000;
            4'd8:    digit_glyph = 7'b0000000;
            4'd9:    digit_glyph = 7'b0010000;
            default: digit_glyph = G_BLANK;
        endcase
    endfunction

    // slot sequencer
    logic [1:0]    slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // shadow capture and BCD converter
    logic [1:0]    sh_mode_q, sh_mode_d;
    logic          sh_blz_q, sh_blz_d;
    logic [6:0]    sh_val_q, sh_val_d;
    logic [1:0]    conv_q, conv_d;
    logic [6:0]    rem_q, rem_d;
    logic [3:0]    tacc_q, tacc_d;
    logic [3:0]    tens_r_q, tens_r_d;
    logic [3:0]    ones_r_q, ones_r_d;
    // per-frame display copy
    logic [1:0]    disp_mode_q, disp_mode_d;
    logic          disp_blz_q, disp_blz_d;
    logic [3:0]    disp_tens_q, disp_tens_d;
    logic [3:0]    disp_ones_q, disp_ones_d;
    // registered pins
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          slot_end, capture, frame_load, in_gap, lit;
    logic [1:0]    digit;
    logic [6:0]    glyph;

    // Slot counter wraps at SLOT_CYCLES-1 and advances the slot (SLOT3 wraps to SLOT0).
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        capture    = (slot_q == SLOT3) && (cnt_q == '0);
        frame_load = (slot_q == SLOT3) && slot_end;
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        slot_d     = slot_end ? slot_q + 2'd1 : slot_q;
    end

    // Capture inputs at SLOT3 start, then convert by repeated subtraction of ten.
    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_blz_d  = sh_blz_q;
        sh_val_d  = sh_val_q;
        conv_d    = conv_q;
        rem_d     = rem_q;
        tacc_d    = tacc_q;
        tens_r_d  = tens_r_q;
        ones_r_d  = ones_r_q;
        if (capture) begin
            sh_mode_d = bus.mode;
            sh_blz_d  = bus.blank_lz;
            sh_val_d  = (bus.value > 7'd99) ? 7'd99 : bus.value;
            rem_d     = sh_val_d;
            tacc_d    = '0;
            conv_d    = C_CONV;
        end else begin
            case (conv_q)
                C_CONV: begin
                    if (rem_q >= 7'd10) begin
                        rem_d  = rem_q - 7'd10;
                        tacc_d = tacc_q + 4'd1;
                    end else begin
                        conv_d = C_DONE;
                    end
                end
                C_DONE: begin
                    tens_r_d = tacc_q;
                    ones_r_d = rem_q[3:0];
                    conv_d   = C_IDLE;
                end
                default: conv_d = C_IDLE;
            endcase
        end
    end

    // Digits read a copy refreshed only at the frame boundary; the SLOT3 digit
    // would otherwise change partway through its own slot after capture.
    always_comb begin
        disp_mode_d = disp_mode_q;
        disp_blz_d  = disp_blz_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        if (frame_load) begin
            disp_mode_d = sh_mode_q;
            disp_blz_d  = sh_blz_q;
            disp_tens_d = tens_r_q;
            disp_ones_d = ones_r_q;
        end
    end

    // Glyph select and gap blanking; a blank digit keeps its anode off all slot.
    always_comb begin
        digit = 2'd3 - slot_q;
        glyph = G_BLANK;
        case (disp_mode_q)
            M_BANNER: begin
                case (digit)
                    2'd3:    glyph = G_C;
                    2'd2:    glyph = G_L;
                    2'd1:    glyph = digit_glyph(4'd0);
                    default: glyph = G_BLANK;
                endcase
            end
            M_NUMBER: begin
                case (digit)
                    2'd3:    glyph = (disp_tens_q == 4'd0 && disp_blz_q) ? G_BLANK
                                                                        : digit_glyph(disp_tens_q);
                    2'd2:    glyph = digit_glyph(disp_ones_q);
                    default: glyph = G_BLANK;
                endcase
            end
            M_WIN:   glyph = (digit <= 2'd1) ? G_U : G_BLANK;
            default: glyph = (digit == 2'd1) ? G_L : G_BLANK;
        endcase
        in_gap = (cnt_q < GAP_END);
        lit    = !in_gap && (glyph != G_BLANK);
        an_d   = lit ? ~(4'b0001 << digit) : 4'b1111;
        seg_d  = lit ? glyph : G_BLANK;
        tick_d = (slot_q == SLOT0) && (cnt_q == '0);
    end

`ifdef SEG_SCAN_DP_HEARTBEAT_EN
    logic [7:0] fcnt_q, fcnt_d;

    // Frame counter; its MSB blinks the digit-2 dp in NUMBER mode.
    always_comb begin
        fcnt_d = tick_q ? fcnt_q + 8'd1 : fcnt_q;
        dp_d   = !((disp_mode_q == M_NUMBER) && (digit == 2'd2) && !in_gap && fcnt_q[7]);
    end

    // Frame counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`else
    // Decimal point stays dark without the heartbeat feature.
    always_comb begin
        dp_d = 1'b1;
    end
`endif

    // All state and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q      <= SLOT3;
            cnt_q       <= '0;
            sh_mode_q   <= M_BANNER;
            sh_blz_q    <= 1'b0;
            sh_val_q    <= '0;
            conv_q      <= C_IDLE;
            rem_q       <= '0;
            tacc_q      <= '0;
            tens_r_q    <= '0;
            ones_r_q    <= '0;
            disp_mode_q <= M_BANNER;
            disp_blz_q  <= 1'b0;
            disp_tens_q <= '0;
            disp_ones_q <= '0;
            seg_q       <= G_BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            sh_mode_q   <= sh_mode_d;
            sh_blz_q    <= sh_blz_d;
            sh_val_q    <= sh_val_d;
            conv_q      <= conv_d;
            rem_q       <= rem_d;
            tacc_q      <= tacc_d;
            tens_r_q    <= tens_r_d;
            ones_r_q    <= ones_r_d;
            disp_mode_q <= disp_mode_d;
            disp_blz_q  <= disp_blz_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule
